// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
// The pipeline side is the master; the arithmetic unit is the slave.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            START;
  logic [2:0]      FUNCT3;
  logic [XLEN-1:0] OP_A;
  logic [XLEN-1:0] OP_B;
  logic            FLUSH;
  logic            BUSY;
  logic            DONE;
  logic [XLEN-1:0] RESULT;

  modport master (
    output START, FUNCT3, OP_A, OP_B, FLUSH,
    input  BUSY, DONE, RESULT
  );

  modport slave (
    input  START, FUNCT3, OP_A, OP_B, FLUSH,
    output BUSY, DONE, RESULT
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand magnitudes,
// UNROLL bits per cycle, with a one-cycle fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input logic     CLK,
  input logic     RESET,
  muldiv_if.slave bus
);
  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic [XLEN-1:0] result_reg;
  logic            done_reg;
  logic [2:0]      funct3_reg;
  logic            a_neg_reg;
  logic            b_neg_reg;
  logic            fast_reg;
  logic [XLEN-1:0] a_mag_reg;
  logic [XLEN-1:0] b_mag_reg;
  logic [XLEN-1:0] hi_reg;
  logic [XLEN-1:0] lo_reg;

  // Operand decode at the request edge
  logic            signed_a;
  logic            signed_b;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            take_fast;
  logic [XLEN-1:0] fast_value;

  assign signed_a = (bus.FUNCT3 == 3'b001) | (bus.FUNCT3 == 3'b010) |
                    (bus.FUNCT3 == 3'b100) | (bus.FUNCT3 == 3'b110);
  assign signed_b = (bus.FUNCT3 == 3'b001) | (bus.FUNCT3 == 3'b100) | (bus.FUNCT3 == 3'b110);
  assign a_neg    = signed_a & bus.OP_A[XLEN-1];
  assign b_neg    = signed_b & bus.OP_B[XLEN-1];
  assign a_mag    = a_neg ? (-bus.OP_A) : bus.OP_A;
  assign b_mag    = b_neg ? (-bus.OP_B) : bus.OP_B;

  assign div_zero   = (bus.OP_B == '0);
  assign div_ovf    = ~bus.FUNCT3[0] & (bus.OP_A == MIN_NEG) & (&bus.OP_B);
  assign take_fast  = bus.FUNCT3[2] & (div_zero | div_ovf);
  assign fast_value = div_zero ? (bus.FUNCT3[1] ? bus.OP_A : {XLEN{1'b1}})
                               : (bus.FUNCT3[1] ? {XLEN{1'b0}} : MIN_NEG);

  // One stage per retired bit; hi holds the partial product high half or the partial remainder,
  // lo holds the multiplier being consumed or the dividend being shifted out / quotient shifted in.
  genvar gi;
  generate
    for (gi = 0; gi < UNROLL; gi++) begin : g_step
      logic [XLEN-1:0] hi_in;
      logic [XLEN-1:0] lo_in;
      logic [XLEN-1:0] hi_out;
      logic [XLEN-1:0] lo_out;
      logic [XLEN:0]   shifted;
      logic [XLEN:0]   mul_sum;
      logic [XLEN-1:0] diff;
      logic            ge;

      if (gi == 0) begin : g_first
        assign hi_in = hi_reg;
        assign lo_in = lo_reg;
      end else begin : g_next
        assign hi_in = g_step[gi-1].hi_out;
        assign lo_in = g_step[gi-1].lo_out;
      end

      assign shifted = {hi_in, lo_in[XLEN-1]};
      assign ge      = (shifted >= {1'b0, b_mag_reg});
      // When the trial subtraction succeeds the difference is below the divisor, so XLEN bits suffice
      assign diff    = shifted[XLEN-1:0] - b_mag_reg;
      assign mul_sum = {1'b0, hi_in} + (lo_in[0] ? {1'b0, a_mag_reg} : {(XLEN+1){1'b0}});

      assign hi_out = funct3_reg[2] ? (ge ? diff : shifted[XLEN-1:0]) : mul_sum[XLEN:1];
      assign lo_out = funct3_reg[2] ? {lo_in[XLEN-2:0], ge} : {mul_sum[0], lo_in[XLEN-1:1]};
    end
  endgenerate

  // Sign fix-up of the unsigned result
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_value;

  assign prod     = {hi_reg, lo_reg};
  assign prod_fix = (a_neg_reg ^ b_neg_reg) ? (-prod) : prod;
  assign quo_fix  = (a_neg_reg ^ b_neg_reg) ? (-lo_reg) : lo_reg;
  assign rem_fix  = a_neg_reg ? (-hi_reg) : hi_reg;

  always_comb begin
    fix_value = '0;
    if (fast_reg) begin
      fix_value = lo_reg;
    end else if (funct3_reg[2]) begin
      fix_value = funct3_reg[1] ? rem_fix : quo_fix;
    end else if (funct3_reg[1:0] == 2'b00) begin
      fix_value = prod_fix[XLEN-1:0];
    end else begin
      fix_value = prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
      funct3_reg <= '0;
      a_neg_reg  <= 1'b0;
      b_neg_reg  <= 1'b0;
      fast_reg   <= 1'b0;
      a_mag_reg  <= '0;
      b_mag_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else if (bus.FLUSH) begin
      state_reg <= IDLE;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A START still held during the DONE cycle belongs to the finished instruction
          if (bus.START && !done_reg) begin
            funct3_reg <= bus.FUNCT3;
            a_neg_reg  <= a_neg;
            b_neg_reg  <= b_neg;
            a_mag_reg  <= a_mag;
            b_mag_reg  <= b_mag;
            hi_reg     <= '0;
            if (take_fast) begin
              fast_reg  <= 1'b1;
              lo_reg    <= fast_value;
              state_reg <= FIX;
            end else begin
              fast_reg  <= 1'b0;
              lo_reg    <= bus.FUNCT3[2] ? a_mag : b_mag;
              count_reg <= CW'(N);
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          hi_reg    <= g_step[UNROLL-1].hi_out;
          lo_reg    <= g_step[UNROLL-1].lo_out;
          count_reg <= count_reg - 1'b1;
          if (count_reg == CW'(1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          result_reg <= fix_value;
          done_reg   <= 1'b1;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.BUSY   = (state_reg != IDLE) | (bus.START & ~done_reg);
  assign bus.DONE   = done_reg;
  assign bus.RESULT = result_reg;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit implementing all eight RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits in the EX stage beside the ALU. It stalls the pipeline through BUSY and returns one registered RESULT with a single-cycle DONE pulse.
- Generalises the single-cycle ALU path with a configurable word width, a configurable number of bits retired per cycle, a fast path for special-case division, and flush abort.

Parameters:
- XLEN, 32, operand and result width. Legal values are 32 and 64.
- UNROLL, 1, bits retired per iteration cycle. Legal values are 1, 2, 4 and 8, and UNROLL must divide XLEN.
- N (localparam), XLEN/UNROLL, number of iteration cycles.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- START  in  1  operation request; held high by EX while the M instruction occupies EX
- FUNCT3  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- OP_A  in  XLEN  rs1 value (multiplicand / dividend)
- OP_B  in  XLEN  rs2 value (multiplier / divisor)
- FLUSH  in  1  branch flush; aborts any operation in flight
- BUSY  out  1  stall request to the pipeline
- DONE  out  1  result-valid pulse
- RESULT  out  XLEN  registered result

Behaviour:
- Reset: RESET is synchronous and active-high, on clock CLK. It forces state IDLE, RESULT=0, DONE=0 and the iteration counter to 0. A reset mid-operation discards all work.
- States: IDLE, CALC, FIX.
  - IDLE: START=1 and DONE=0 is sampled at the edge. OP_A, OP_B and FUNCT3 are latched, and the signs and magnitudes are computed:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: A signed, B unsigned.
    - All other ops: unsigned.
    - The magnitude of the most-negative value is 2^(XLEN-1) and is held as unsigned.
  - IDLE transitions:
    - Special-case divide → FIX.
    - Otherwise → CALC with counter=N.
  - CALC: each edge retires UNROLL bits.
    - Multiply: shift-add into a 2*XLEN accumulator.
    - Divide: restoring, producing UNROLL quotient bits, with the remainder held in XLEN+1 bits.
    - Counter decrements each edge. At the edge where counter==1 → FIX.
  - FIX: at the next edge RESULT is loaded, DONE=1 for exactly one cycle, and state → IDLE.
    - Multiply product: negated if its sign is set.
    - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
    - Quotient is negated if sign(A) xor sign(B), for DIV only.
    - Remainder takes the sign of the dividend, for REM only.
- Latency: START high in cycle 0. DONE is high in cycle N+2 (cycle 34 for XLEN=32, UNROLL=1). Fast path: DONE in cycle 2.
- Special cases (fast path, no CALC):
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return OP_A.
  - Signed overflow (DIV/REM with A=-2^(XLEN-1), B=-1): DIV returns -2^(XLEN-1); REM returns 0.
- BUSY = (state != IDLE) | (START & ~DONE). It is combinational. BUSY=0 in the DONE cycle, so the pipeline advances at that edge.
- START is ignored in the cycle DONE=1, so no restart occurs on a still-held START. Back-to-back M instructions are supported: the next START in cycle N+3 begins a new operation.
- RESULT holds its value until the next FIX edge, RESET, or nothing else. FLUSH does not alter RESULT.
- FLUSH is synchronous:
  - Any state → IDLE, counter=0; no DONE is produced.
  - FLUSH has priority over START in the same cycle.
  - FLUSH in the FIX cycle suppresses DONE and the RESULT update.
- RESET has priority over FLUSH.
- Operand changes on OP_A/OP_B after the START edge are ignored.

Test Plan:
- MUL: OP_A=7, OP_B=-3, FUNCT3=000, XLEN=32, UNROLL=1 → DONE in cycle 34 with RESULT=0xFFFFFFEB. BUSY is high in cycles 0–33 and low in cycle 34.
- MULH variants:
  - OP_A=0x80000000, OP_B=0xFFFFFFFF, MULH → RESULT=0x00000000.
  - Same operands, MULHSU → RESULT=0x80000000.
  - Same operands, MULHU → RESULT=0x7FFFFFFF.
- DIV/REM: OP_A=-7, OP_B=2:
  - DIV → RESULT=0xFFFFFFFD.
  - REM → RESULT=0xFFFFFFFF.
  - DIVU → RESULT=0x7FFFFFFC.
  - Repeat with UNROLL=4: DONE in cycle 10 with identical RESULTs.
- Fast path:
  - DIVU with OP_B=0 → DONE in cycle 2, RESULT=0xFFFFFFFF.
  - REM with OP_A=0x80000000, OP_B=-1 → DONE in cycle 2, RESULT=0.
  - DIV with OP_A=0x80000000, OP_B=-1 → RESULT=0x80000000.
- Flush/reset abort:
  - DIV started, FLUSH pulsed in cycle 10 → state IDLE, no DONE, RESULT unchanged, BUSY=0 in cycle 11 with START low.
  - RESET pulsed mid-CALC → RESULT=0, DONE=0.
- Back-to-back with START held high:
  - After DONE, START held for one cycle → no second DONE.
  - New operands with START in cycle 35 → second DONE in cycle 69.
